// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared types and helpers for dff_share_arbiter.
//   arb_state_e : arbiter FSM states (IDLE, OWNED)
//   pick_t      : round-robin pick result (valid flag + index)
//   rr_pick()   : first set request bit scanning ptr, ptr+1, ... wrapping at n-1
//   idx_w()     : index width for n requesters (at least 1 bit)
package dff_arb_pkg;

    localparam int MAX_N = 16;
    localparam int PTR_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
    } pick_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Only the low n bits of req take part; the scan visits each of them once.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input logic [PTR_W-1:0] ptr,
                                      input int               n);
        pick_t p;
        int    k;
        p = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && !p.valid) begin
                k = int'(ptr) + i;
                if (k >= n) k = k - n;
                if (req[k]) begin
                    p.valid = 1'b1;
                    p.idx   = k[PTR_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_dff.sv
// dff: plain WIDTH-bit storage register. The arbiter supplies the full next
// value (including reset and hold), so this is just a flop.
//   clk : clock
//   d   : next value
//   q   : register contents
module dff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        q <= d;
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: round-robin arbiter sequencing burst writes from N
// requesters into one shared WIDTH-bit register.
//   clk, rst  : clock, synchronous active-high reset
//   req/last  : per-requester request and burst-release flag
//   wdata     : per-requester write data, requester i at [i*WIDTH +: WIDTH]
//   gnt       : registered one-hot grant;  busy = |gnt
//   owner     : current (or most recent) owner index
//   q         : shared register contents
//   wr_pulse  : high the cycle after each register write
//   timeout   : (ARB_TIMEOUT_EN only) high the cycle after a forced release
// Optional feature macro: ARB_TIMEOUT_EN (bounds ownership to MAX_HOLD cycles).
module dff_share_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = idx_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       last,
    input  logic [N*WIDTH-1:0] wdata,
    output logic [N-1:0]       gnt,
    output logic               busy,
    output logic [IDX_W-1:0]   owner,
    output logic [WIDTH-1:0]   q,
    output logic               wr_pulse
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    if (N < 1 || N > MAX_N) begin : g_bad_n
        $error("dff_share_arbiter: N out of range");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("dff_share_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [WIDTH-1:0] q_d;

    logic             write;
    logic             release_own;
    logic             forced;
    logic [MAX_N-1:0] cand;
    logic [IDX_W-1:0] scan_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] pick_idx;
    pick_t            pick;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        write       = 1'b0;
        release_own = 1'b0;
        forced      = 1'b0;
        next_ptr    = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
        forced      = (state_q == OWNED) && req[owner_q] && !last[owner_q] &&
                      (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

        // In IDLE scan all requests from ptr; on release scan from owner+1
        // with the releasing requester masked, so it can only win later.
        cand          = '0;
        cand[N-1:0]   = req;
        scan_ptr      = ptr_q;
        if (state_q == OWNED) begin
            write       = req[owner_q];
            release_own = !req[owner_q] || last[owner_q] || forced;
            cand[owner_q] = 1'b0;
            scan_ptr    = next_ptr;
        end
        pick     = rr_pick(cand, PTR_W'(scan_ptr), N);
        pick_idx = IDX_W'(pick.idx);

        if (state_q == IDLE || release_own) begin
            if (state_q == OWNED) ptr_d = next_ptr;
            if (pick.valid) begin
                state_d         = OWNED;
                owner_d         = pick_idx;
                gnt_d           = '0;
                gnt_d[pick_idx] = 1'b1;
`ifdef ARB_TIMEOUT_EN
                hold_d          = '0;
`endif
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
`ifdef ARB_TIMEOUT_EN
        else begin
            hold_d = hold_q + 1'b1;
        end
        timeout_d = forced;
`endif

        wr_pulse_d = write;
        q_d = rst   ? '0 :
              write ? wdata[int'(owner_q)*WIDTH +: WIDTH] : q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`endif

    dff #(.WIDTH(WIDTH)) u_dff (
        .clk (clk),
        .d   (q_d),
        .q   (q)
    );

    assign gnt      = gnt_q;
    assign busy     = |gnt_q;
    assign owner    = owner_q;
    assign wr_pulse = wr_pulse_q;

endmodule
